// File: rtl/fetch_pc_if.sv
// Fetch-stage bundle: EX redirect inputs, hazard stall, instruction-memory port,
// IF/ID register outputs and performance counters.
interface fetch_pc_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  branch_taken_i;
  logic [DATA_WIDTH-1:0] branch_target_i;
  logic                  jump_i;
  logic [DATA_WIDTH-1:0] jump_target_i;
  logic                  stall_i;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic [DATA_WIDTH-1:0] if_id_pc_o;
  logic [DATA_WIDTH-1:0] if_id_inst_o;
  logic                  if_id_valid_o;
  logic                  flush_o;
  logic                  misalign_o;
  logic [CNT_WIDTH-1:0]  redirect_cnt_o;
  logic [CNT_WIDTH-1:0]  stall_cnt_o;

  modport master (
    output branch_taken_i, branch_target_i, jump_i, jump_target_i, stall_i, imem_rdata_i,
    input  imem_addr_o, if_id_pc_o, if_id_inst_o, if_id_valid_o, flush_o, misalign_o,
           redirect_cnt_o, stall_cnt_o
  );

  modport slave (
    input  branch_taken_i, branch_target_i, jump_i, jump_target_i, stall_i, imem_rdata_i,
    output imem_addr_o, if_id_pc_o, if_id_inst_o, if_id_valid_o, flush_o, misalign_o,
           redirect_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: program counter, EX-driven redirect with IF/ID squash,
// load-use stall hold, sticky misalign flag and saturating perf counters.
module fetch_pc_unit #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  fetch_pc_if.slave  bus
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] if_id_pc_q, if_id_pc_d;
  logic [DATA_WIDTH-1:0] if_id_inst_q, if_id_inst_d;
  logic                  if_id_valid_q, if_id_valid_d;
  logic                  misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  redirect_cnt_q, redirect_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

  logic                  taken;
  logic                  redirect;
  logic [DATA_WIDTH-1:0] target_raw;
  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    // An unknown taken flag (no branch in EX) must never steer the PC.
    taken          = (bus.branch_taken_i === 1'b1);
    redirect       = taken | bus.jump_i;
    target_raw     = bus.jump_i ? bus.jump_target_i : bus.branch_target_i;
    target         = {target_raw[DATA_WIDTH-1:2], 2'b00};

    pc_d           = pc_q;
    if_id_pc_d     = if_id_pc_q;
    if_id_inst_d   = if_id_inst_q;
    if_id_valid_d  = if_id_valid_q;
    misalign_d     = misalign_q;
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;

    if (redirect) begin
      // Redirect beats stall: the held ID instruction is wrong-path and is squashed.
      pc_d           = target;
      if_id_pc_d     = '0;
      if_id_inst_d   = NOP;
      if_id_valid_d  = 1'b0;
      redirect_cnt_d = sat_inc(redirect_cnt_q);
      if (target_raw[1:0] != 2'b00) misalign_d = 1'b1;
    end else if (bus.stall_i) begin
      stall_cnt_d    = sat_inc(stall_cnt_q);
    end else begin
      pc_d           = pc_q + DATA_WIDTH'(4);
      if_id_pc_d     = pc_q;
      if_id_inst_d   = bus.imem_rdata_i;
      if_id_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q           <= RESET_PC;
      if_id_pc_q     <= '0;
      if_id_inst_q   <= NOP;
      if_id_valid_q  <= 1'b0;
      misalign_q     <= 1'b0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_inst_q   <= if_id_inst_d;
      if_id_valid_q  <= if_id_valid_d;
      misalign_q     <= misalign_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign bus.imem_addr_o    = pc_q;
  assign bus.if_id_pc_o     = if_id_pc_q;
  assign bus.if_id_inst_o   = if_id_inst_q;
  assign bus.if_id_valid_o  = if_id_valid_q;
  assign bus.flush_o        = redirect;
  assign bus.misalign_o     = misalign_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;
  assign bus.stall_cnt_o    = stall_cnt_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage: owns the program counter, drives the instruction-memory address and holds the IF/ID pipeline register. It sits directly downstream of the EX-stage branch checker. It consumes the checker's taken decision and the EX-computed targets, redirects the PC, and squashes wrong-path instructions. It also keeps taken-redirect and stall-cycle counters for performance debug.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `DATA_WIDTH`, default 32: PC, target and instruction width.
- `CNT_WIDTH`, default 16: width of the performance counters.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `branch_taken_i`  in  1  taken decision from the branch checker, for the instruction currently in EX.
- `branch_target_i`  in  DATA_WIDTH  branch target computed in EX.
- `jump_i`  in  1  JAL/JALR in EX; unconditional redirect.
- `jump_target_i`  in  DATA_WIDTH  jump target computed in EX.
- `stall_i`  in  1  load-use stall from the hazard unit; hold PC and IF/ID.
- `imem_addr_o`  out  DATA_WIDTH  instruction-memory address, equal to `pc_q`.
- `imem_rdata_i`  in  DATA_WIDTH  instruction word; combinational read of `imem_addr_o`.
- `if_id_pc_o`  out  DATA_WIDTH  PC of the instruction in ID.
- `if_id_inst_o`  out  DATA_WIDTH  instruction in ID.
- `if_id_valid_o`  out  1  ID slot holds a real instruction.
- `flush_o`  out  1  combinational; tells the ID/EX register to load a bubble this cycle.
- `misalign_o`  out  1  sticky; set when any redirect target has bits [1:0] != 0.
- `redirect_cnt_o`  out  CNT_WIDTH  number of taken redirects.
- `stall_cnt_o`  out  CNT_WIDTH  number of stalled cycles.

## Operation

- `redirect` = `branch_taken_i | jump_i`.
- `target` = `jump_i ? jump_target_i : branch_target_i`. Jump wins if both inputs are set.
- `target` is always force-aligned: bits [1:0] are cleared before use.
- Next-PC priority, highest first:
  1. redirect: `pc_q <= target`. IF/ID loads a bubble: inst = NOP (32'h0000_0013), valid = 0, pc = 0. `flush_o` = 1.
  2. `stall_i`: `pc_q`, IF/ID and valid all hold.
  3. Otherwise: `pc_q <= pc_q + 4`, with mod 2^DATA_WIDTH wrap-around. IF/ID loads pc = `pc_q`, inst = `imem_rdata_i`, valid = 1.
- Redirect and stall in the same cycle: redirect wins. The stalled instruction in ID is on the wrong path and is squashed.
- `flush_o` = `redirect`. It is purely combinational and independent of `stall_i`.
- `misalign_o` sets when `redirect` is true and the un-aligned target has bits [1:0] != 0. It clears only on reset.
- `redirect_cnt_o` increments on every redirect cycle.
- `stall_cnt_o` increments on every cycle where `stall_i` = 1 and `redirect` = 0.
- Both counters saturate at all-ones; they do not wrap.
- X on `branch_taken_i` when no branch is in EX must not propagate into `pc_q`. Use `branch_taken_i === 1'b1` semantics in the bench; the RTL must treat non-1 as 0.

## Timing

- Reset (async assert, sync-safe release):
  - `pc_q` = RESET_PC, so `imem_addr_o` = RESET_PC.
  - `if_id_pc_o` = 0, `if_id_inst_o` = NOP, `if_id_valid_o` = 0.
  - `misalign_o` = 0 and both counters = 0.
  - `flush_o` follows its inputs.
- First edge after reset release: IF/ID captures the instruction at RESET_PC, with valid = 1.
- Sequential fetch: 1 instruction per cycle. IF to ID latency is 1 cycle.
- Redirect penalty: 2 cycles.
  - The IF/ID bubble is produced by this block.
  - The ID/EX bubble is produced via `flush_o`.
  - The target instruction reaches ID on the 2nd edge after the redirect cycle.
- Reset asserted mid-stall or mid-redirect: state returns to reset values immediately. No pending redirect survives.

## Test plan

- Reset with RESET_PC = 32'h100, no stall, memory returns the word address as data → `imem_addr_o` = 100, 104, 108 on successive cycles; `if_id_pc_o` trails by one cycle; `if_id_valid_o` rises on the first edge.
- `branch_taken_i` = 1 with target 32'h200 while `pc_q` = 32'h10C → `flush_o` = 1 that cycle. Next cycle: `pc_q` = 32'h200, `if_id_valid_o` = 0, `if_id_inst_o` = 32'h13. `redirect_cnt_o` = 1.
- `stall_i` = 1 for 3 cycles at `pc_q` = 32'h40 → PC and IF/ID hold, then resume at 32'h44. `stall_cnt_o` = 3.
- `stall_i` = 1 and `jump_i` = 1 (target 32'h80) together, with `branch_taken_i` = 1 (target 32'h90) → `pc_q` = 32'h80, IF/ID bubble, `stall_cnt_o` unchanged.
- Jump target 32'h0000_0083 → `pc_q` = 32'h80 and `misalign_o` = 1, staying 1 until `rst_ni` is pulsed low.
- Wrap and saturation: `pc_q` = 32'hFFFF_FFFC with no stall → next `pc_q` = 0. With CNT_WIDTH = 4, 20 redirects → `redirect_cnt_o` = 4'hF.
